// File: rtl/crack_ctrl.sv
// Key-search controller: steps arc4 keys 0..KEY_MAX and checks each plaintext for printability.
// Optional CRACK_EARLY_ABORT_EN: leave CHECK on the first non-printable byte instead of reading all.
module crack_ctrl #(
   parameter logic [23:0] KEY_MAX  = 24'hFFFFFF,
   parameter logic [7:0]  PRINT_LO = 8'h20,
   parameter logic [7:0]  PRINT_HI = 8'h7E
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   output logic [23:0] key,
   output logic        key_valid,
   output logic        arc_en,
   input  logic        arc_rdy,
   output logic [23:0] arc_key,
   output logic        pt_sel,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata
);

   typedef enum logic [3:0] {
      StIdle, StStart, StWaitBusy, StWaitDone, StLenRd, StLenLat, StCheck, StNext, StDone
   } state_e;

   state_e      state_q, state_d;
   logic [23:0] arc_key_q, arc_key_d;
   logic [23:0] key_q, key_d;
   logic        key_valid_q, key_valid_d;
   logic [7:0]  len_q, len_d;
   logic [8:0]  index_q, index_d;
   logic        fail_q, fail_d;

   logic byte_ok, byte_bad, last;

   assign byte_ok = (pt_rddata >= PRINT_LO) && (pt_rddata <= PRINT_HI);
   // Data returned in CHECK belongs to address index_q-1; index 1 data arrives when index_q == 2.
   assign byte_bad = (index_q >= 9'd2) && !byte_ok;
   assign last     = (index_q == ({1'b0, len_q} + 9'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         arc_key_q   <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         len_q       <= '0;
         index_q     <= '0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         arc_key_q   <= arc_key_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         len_q       <= len_d;
         index_q     <= index_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      arc_key_d   = arc_key_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      len_d       = len_q;
      index_d     = index_q;
      fail_d      = fail_q;
      arc_en      = 1'b0;
      pt_sel      = 1'b0;
      pt_addr     = '0;

      unique case (state_q)
         StIdle: begin
            if (en) begin
               arc_key_d   = '0;
               key_valid_d = 1'b0;
               state_d     = StStart;
            end
         end
         StStart: begin
            if (arc_rdy) begin
               arc_en  = 1'b1;
               state_d = StWaitBusy;
            end
         end
         StWaitBusy: begin
            if (!arc_rdy) state_d = StWaitDone;
         end
         StWaitDone: begin
            if (arc_rdy) state_d = StLenRd;
         end
         StLenRd: begin
            pt_sel  = 1'b1;
            state_d = StLenLat;
         end
         StLenLat: begin
            pt_sel  = 1'b1;
            len_d   = pt_rddata;
            index_d = 9'd1;
            fail_d  = 1'b0;
            if (pt_rddata == 8'd0) begin
               key_d       = arc_key_q;
               key_valid_d = 1'b1;
               state_d     = StDone;
            end else begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            pt_sel  = 1'b1;
            if (!last) pt_addr = index_q[7:0];
            index_d = index_q + 9'd1;
            fail_d  = fail_q | byte_bad;
            if (last) begin
               if (fail_d) begin
                  state_d = StNext;
               end else begin
                  key_d       = arc_key_q;
                  key_valid_d = 1'b1;
                  state_d     = StDone;
               end
            end
`ifdef CRACK_EARLY_ABORT_EN
            // Suppress the next address so no byte past the failing one is fetched.
            if (byte_bad) begin
               pt_addr = '0;
               state_d = StNext;
            end
`endif
         end
         StNext: begin
            if (arc_key_q == KEY_MAX) begin
               key_valid_d = 1'b0;
               key_d       = KEY_MAX;
               state_d     = StDone;
            end else begin
               arc_key_d = arc_key_q + 24'd1;
               state_d   = StStart;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign rdy       = (state_q == StIdle);
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign arc_key   = arc_key_q;

endmodule

// File: tb/tb_crack_ctrl.sv
// Randomised bench for crack_ctrl: behavioural arc4/RAM model plus a search-level reference model.
module tb_crack_ctrl;
   localparam logic [23:0] KeyMax  = 24'h000007;
   localparam int          NumKeys = 8;

   logic        clk, rst_n, en, rdy, key_valid, arc_en, arc_rdy, pt_sel;
   logic [23:0] key, arc_key;
   logic [7:0]  pt_addr, pt_rddata;

   crack_ctrl #(.KEY_MAX(KeyMax)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
      .arc_en(arc_en), .arc_rdy(arc_rdy), .arc_key(arc_key), .pt_sel(pt_sel),
      .pt_addr(pt_addr), .pt_rddata(pt_rddata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Plaintext per key: byte 0 is the length, bytes 1..len the message.
   logic [7:0] msgs [0:NumKeys*256-1];
   logic [2:0] arc_cur;
   int         busy_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arc_rdy  <= 1'b1;
         busy_cnt <= 0;
         arc_cur  <= '0;
      end else if (arc_en && arc_rdy) begin
         arc_rdy  <= 1'b0;
         busy_cnt <= 3 + int'($urandom % 4);
         arc_cur  <= arc_key[2:0];
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
         if (busy_cnt == 1) arc_rdy <= 1'b1;
      end
   end

   always @(posedge clk) pt_rddata <= msgs[{arc_cur, pt_addr}];

   // Per-search observations; the epoch counter lets the stimulus restart them.
   int   epoch = 0, mon_epoch = 0, pulses = 0, max_addr = 0, seq_err = 0, viol = 0;
   logic prev_arc_en = 1'b0;

   always @(negedge clk) begin
      if (mon_epoch != epoch) begin
         mon_epoch = epoch;
         pulses    = 0;
         max_addr  = 0;
         seq_err   = 0;
      end
      if (arc_en) begin
         if (int'(arc_key) != pulses) seq_err++;
         pulses++;
      end
      if (arc_en && prev_arc_en) viol++;
      if (!pt_sel && pt_addr != 8'd0) viol++;
      if (pt_sel && int'(pt_addr) > max_addr) max_addr = int'(pt_addr);
      prev_arc_en = arc_en;
   end

   function automatic logic [7:0] rand_good();
      case ($urandom % 10)
         0:       return 8'h20;
         1:       return 8'h7E;
         default: return 8'h21 + 8'($urandom % 93);
      endcase
   endfunction

   function automatic logic [7:0] rand_bad();
      case ($urandom % 4)
         0:       return 8'h1F;
         1:       return 8'h7F;
         2:       return 8'($urandom % 32);
         default: return 8'h80 + 8'($urandom % 128);
      endcase
   endfunction

   task automatic set_msg(input int k, input int len, input int bad_idx);
      msgs[k*256] = 8'(len);
      for (int i = 1; i < 256; i++) msgs[k*256+i] = (i <= len) ? rand_good() : rand_bad();
      if (bad_idx != 0) msgs[k*256+bad_idx] = rand_bad();
   endtask

   // Search outcome from the plaintext table: first all-printable key wins.
   task automatic ref_search(output int ek, output int ev, output int ep, output int ea);
      ek = NumKeys - 1; ev = 0; ep = NumKeys; ea = 0;
      for (int k = 0; k < NumKeys; k++) begin
         int len, first_bad, reach;
         len = int'(msgs[k*256]);
         first_bad = 0;
         for (int i = 1; i <= len; i++)
            if (first_bad == 0 && (msgs[k*256+i] < 8'h20 || msgs[k*256+i] > 8'h7E)) first_bad = i;
`ifdef CRACK_EARLY_ABORT_EN
         reach = (first_bad != 0) ? first_bad : len;
`else
         reach = len;
`endif
         if (reach > ea) ea = reach;
         if (first_bad == 0) begin
            ek = k; ev = 1; ep = k + 1;
            break;
         end
      end
   endtask

   task automatic run_search(input string tag);
      int ek, ev, ep, ea, n;
      ref_search(ek, ev, ep, ea);
      epoch++;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      n = 0;
      while (!rdy && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check({tag, ".done"}, 32'(rdy), 32'd1);
      check({tag, ".key"}, 32'(key), 32'(ek));
      check({tag, ".key_valid"}, 32'(key_valid), 32'(ev));
      check({tag, ".pulses"}, 32'(pulses), 32'(ep));
      check({tag, ".max_addr"}, 32'(max_addr), 32'(ea));
      check({tag, ".key_seq"}, 32'(seq_err), 32'd0);
      check({tag, ".protocol"}, 32'(viol), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0;
      en    = 1'b0;
      for (int k = 0; k < NumKeys; k++) set_msg(k, 4, 1);
      #12;
      check("rst.rdy", 32'(rdy), 32'd1);
      check("rst.key", 32'(key), 32'd0);
      check("rst.arc_key", 32'(arc_key), 32'd0);
      check("rst.pt_addr", 32'(pt_addr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("idle.rdy", 32'(rdy), 32'd1);
         check("idle.key_valid", 32'(key_valid), 32'd0);
         check("idle.arc_en", 32'(arc_en), 32'd0);
         check("idle.pt_sel", 32'(pt_sel), 32'd0);
      end

      for (int k = 0; k < NumKeys; k++) begin
         set_msg(k, 1 + int'($urandom % 6), 0);
         msgs[k*256+1] = 8'h01;
      end
      set_msg(3, 5, 0);
      msgs[3*256+1] = "H"; msgs[3*256+2] = "E"; msgs[3*256+3] = "L";
      msgs[3*256+4] = "L"; msgs[3*256+5] = "O";
      run_search("hello");

      for (int k = 0; k < NumKeys; k++) begin
         n = 1 + int'($urandom % 8);
         set_msg(k, n, 1 + int'($urandom % n));
      end
      run_search("nokey");

      set_msg(0, 0, 0);
      run_search("len0");

      for (int k = 0; k < NumKeys; k++) set_msg(k, 10, 2);
      run_search("abort");

      set_msg(0, 255, 0);
      run_search("len255");

      // Reset while the controller waits for the arc4 core to finish.
      for (int k = 0; k < NumKeys; k++) set_msg(k, 10, 2);
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      n = 0;
      while (arc_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("midrst.busy_seen", 32'(arc_rdy), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.rdy", 32'(rdy), 32'd1);
      check("midrst.key", 32'(key), 32'd0);
      check("midrst.key_valid", 32'(key_valid), 32'd0);
      check("midrst.arc_en", 32'(arc_en), 32'd0);
      check("midrst.arc_key", 32'(arc_key), 32'd0);
      check("midrst.pt_sel", 32'(pt_sel), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set_msg(2, 6, 0);
      run_search("post_rst");

      for (int t = 0; t < 25; t++) begin
         for (int k = 0; k < NumKeys; k++) begin
            n = int'($urandom % 16);
            set_msg(k, n, ((n > 0) && ($urandom % 3 != 0)) ? 1 + int'($urandom % n) : 0);
         end
         run_search($sformatf("rand%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/crack_ctrl.md
CRACK_CTRL -- requirements
Module: crack_ctrl

Interface
REQ-001 Parameter: KEY_MAX, 24'hFFFFFF, last key value tried (inclusive).
REQ-002 Parameter: PRINT_LO, 8'h20, lowest byte value accepted as printable.
REQ-003 Parameter: PRINT_HI, 8'h7E, highest byte value accepted as printable.
REQ-004 Port: clk  input  1  single clock, all state on rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: en  input  1  start key search; sampled only while rdy=1.
REQ-007 Port: rdy  output  1  high when idle and able to accept en.
REQ-008 Port: key  output  24  result key; meaningful only when rdy=1 after a search.
REQ-009 Port: key_valid  output  1  high when key decrypts to all-printable plaintext.
REQ-010 Port: arc_en  output  1  one-cycle start pulse to arc4 core.
REQ-011 Port: arc_rdy  input  1  arc4 core ready/done.
REQ-012 Port: arc_key  output  24  key driven to arc4 core.
REQ-013 Port: pt_sel  output  1  high while controller owns plaintext RAM read port (external mux select).
REQ-014 Port: pt_addr  output  8  plaintext RAM read address.
REQ-015 Port: pt_rddata  input  8  plaintext RAM read data, valid one cycle after pt_addr (synchronous RAM).

Function
REQ-016 States: IDLE, START, WAIT_BUSY, WAIT_DONE, LEN_RD, LEN_LAT, CHECK, NEXT, DONE.
REQ-017 IDLE: rdy=1; en=1 -> arc_key<=0, key_valid<=0, go START.
REQ-018 START: when arc_rdy=1 assert arc_en for exactly one cycle, go WAIT_BUSY; else hold with arc_en=0.
REQ-019 WAIT_BUSY: wait for arc_rdy=0, then WAIT_DONE; WAIT_DONE: wait for arc_rdy=1, then LEN_RD.
REQ-020 LEN_RD: pt_sel=1, pt_addr=0; LEN_LAT: capture pt_rddata as len, index<=1.
REQ-021 len=0 -> key accepted immediately (empty message printable): key<=arc_key, key_valid<=1, go DONE.
REQ-022 CHECK: issue pt_addr=index each cycle, compare returned byte (one-cycle lag) against PRINT_LO..PRINT_HI inclusive; last compared byte index = len.
REQ-023 All len bytes printable -> key<=arc_key, key_valid<=1, go DONE.
REQ-024 Any byte non-printable -> mark fail; go NEXT (timing per REQ-033/034).
REQ-025 NEXT: arc_key==KEY_MAX -> key_valid<=0, key<=KEY_MAX, go DONE; else arc_key<=arc_key+1, go START.
REQ-026 DONE: one cycle, go IDLE; key and key_valid hold until next accepted en.
REQ-027 en while rdy=0 ignored; en held high in IDLE restarts a new search from key 0.
REQ-028 pt_sel=1 only in LEN_RD, LEN_LAT, CHECK; pt_addr=0 otherwise.
REQ-029 arc_en never asserted outside START; never high two consecutive cycles.
REQ-030 index is 9 bits internally so len=255 terminates without wrap.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE, rdy=1, key=0, key_valid=0, arc_en=0, arc_key=0, pt_sel=0, pt_addr=0.
REQ-032 Reset mid-search abandons the search; no partial result retained.

Configuration
REQ-033 Macro CRACK_EARLY_ABORT_EN defined: first non-printable byte exits CHECK to NEXT on the cycle its compare completes, remaining bytes unread.
REQ-034 Macro CRACK_EARLY_ABORT_EN undefined: CHECK always reads all len bytes, fail flag accumulated, decision taken after byte len.

Verification
REQ-035 Reset held low then released, en=0 -> rdy=1, key_valid=0, arc_en=0, pt_sel=0 indefinitely.
REQ-036 Model arc4 + RAM; plaintext for key 24'h000003 is len=5 "HELLO", other keys give byte 8'h01 at index 1 -> after search rdy=1, key=24'h000003, key_valid=1, exactly 4 arc_en pulses.
REQ-037 KEY_MAX=24'h000007, no key printable -> 8 arc_en pulses, then key_valid=0, key=24'h000007.
REQ-038 len=0 for key 0 -> key=0, key_valid=1 after first arc4 completion, no CHECK reads.
REQ-039 Failing byte at index 2 of len=10: with CRACK_EARLY_ABORT_EN highest pt_addr read = 2; without it highest pt_addr = 10.
REQ-040 rst_n pulsed low during WAIT_DONE -> outputs return to reset values same cycle; subsequent en restarts from arc_key=0.
